// File: rtl/fifo_wr_pkg.sv
// Shared definitions for the dual-clock test FIFO controllers.
// State encoding and a width helper usable in parameter/port declarations.
package fifo_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } fifo_state_t;

  // ceil(log2(n)), never less than 1 so registers always have a bit
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr.sv
// Write-side controller for the dual-clock test FIFO: waits for a settled
// empty flag, then writes an incrementing pattern until full or DEPTH words.
module fifo_wr
  import fifo_wr_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              DEPTH      = 256,
  parameter int              SETTLE_CYC = 10,
  parameter logic [DATA_W-1:0] DATA_INIT = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        wrempty,
  input  logic                        wrfull,
  output logic                        wrreq,
  output logic [DATA_W-1:0]           wrdata,
  output logic [clog2(DEPTH+1)-1:0]   wr_cnt,
  output logic                        busy,
  output logic                        burst_done
);

  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int SET_W = clog2(SETTLE_CYC);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);
  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC - 1);

  fifo_state_t       state, state_nx;
  logic [SET_W-1:0]  scnt, scnt_nx;
  logic              wrreq_nx, done_nx, accept;
  logic [DATA_W-1:0] wrdata_nx;
  logic [CNT_W-1:0]  wr_cnt_nx;

  // The FIFO drops a write presented while full, so only this advances data
  assign accept = wrreq & ~wrfull;

  always_comb begin
    state_nx  = state;
    scnt_nx   = scnt;
    wrreq_nx  = 1'b0;
    done_nx   = 1'b0;
    wrdata_nx = accept ? wrdata + 1'b1 : wrdata;
    wr_cnt_nx = accept ? wr_cnt + 1'b1 : wr_cnt;
    case (state)
      ST_IDLE: begin
        if (en && wrempty) begin
          state_nx  = ST_SETTLE;
          scnt_nx   = SETTLE_LD;
          wr_cnt_nx = '0;
        end
      end
      ST_SETTLE: begin
        if (!wrempty) begin
          state_nx = ST_IDLE;
        end else if (scnt == '0) begin
          state_nx = ST_WRITE;
          wrreq_nx = 1'b1;
        end else begin
          scnt_nx = scnt - 1'b1;
        end
      end
      ST_WRITE: begin
        // full wins: that cycle is not accepted, so no count/data update
        if (wrfull || wr_cnt == LAST_CNT) begin
          state_nx = ST_DONE;
          done_nx  = 1'b1;
        end else begin
          wrreq_nx = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      scnt       <= '0;
      wrreq      <= 1'b0;
      wrdata     <= DATA_INIT;
      wr_cnt     <= '0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nx;
      scnt       <= scnt_nx;
      wrreq      <= wrreq_nx;
      wrdata     <= wrdata_nx;
      wr_cnt     <= wr_cnt_nx;
      busy       <= (state_nx != ST_IDLE);
      burst_done <= done_nx;
    end
  end

endmodule

// File: doc/fifo_wr.md
Name: fifo_wr

Overview:
- Write-side controller for the dual-clock test FIFO. It is the counterpart of the read controller, which waits for full and then drains the FIFO to empty.
- Waits for the FIFO to report empty and lets the flag settle. It then writes a continuous incrementing data pattern until the FIFO reports full or one burst of DEPTH words has been accepted.
- Sits on the FIFO write-clock domain. The read side checks pattern continuity across bursts.

Parameters:
- DATA_W, 8: width of wrdata.
- DEPTH, 256: maximum words accepted per burst (FIFO capacity); must be >= 1.
- SETTLE_CYC, 10: cycles wrempty must stay high before writing starts. Covers the lag of flags crossing the clock domain. Must be >= 1.
- DATA_INIT, 0: wrdata value after reset.

Ports:
- clk  input  1  write-side clock; all logic on posedge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- en  input  1  allows a new burst to start; sampled only in IDLE.
- wrempty  input  1  FIFO write-side empty flag.
- wrfull  input  1  FIFO write-side full flag.
- wrreq  output  1  write request, registered.
- wrdata  output  DATA_W  write data, registered.
- wr_cnt  output  clog2(DEPTH+1)  words accepted in the current/last burst.
- busy  output  1  high in any state other than IDLE.
- burst_done  output  1  one-cycle pulse at burst end.

Behaviour:
- Reset values (asynchronous): wrreq=0, wrdata=DATA_INIT, wr_cnt=0, busy=0, burst_done=0, state=IDLE, settle counter=0.
- Accepted write: a cycle with wrreq=1 and wrfull=0. Only an accepted write advances wrdata (+1, modulo 2^DATA_W, wrapping from all-ones to 0) and increments wr_cnt. A write attempted while full is ignored by the FIFO, so no data is lost.
- IDLE:
  - wrreq=0.
  - If en && wrempty: go to SETTLE, load settle counter with SETTLE_CYC-1, clear wr_cnt.
- SETTLE:
  - If wrempty=0 on any cycle: return to IDLE. This is a spurious empty; no write occurs.
  - Else if counter==0: go to WRITE and assert wrreq on the same edge.
  - Else decrement the counter.
  - Minimum latency from en&&wrempty sampled to the first wrreq=1 is SETTLE_CYC+1 cycles.
- WRITE:
  - wrreq stays 1.
  - Exit to DONE, deasserting wrreq on the same edge, when either:
    - wrfull=1 is sampled, or
    - the current accepted write makes wr_cnt reach DEPTH.
  - With a lagging wrfull, the cycle where wrfull is seen is not accepted; wrdata holds.
  - If both exit conditions hold on the same cycle, exit once; the full flag takes precedence and that write is not counted.
- DONE:
  - burst_done=1 for exactly one cycle, wrreq=0, then IDLE.
  - wr_cnt holds until the next SETTLE entry.
  - wrdata is NOT reset between bursts, so the pattern continues from the last unwritten value.
- en is ignored outside IDLE; a burst cannot be aborted except by rst.
- rst mid-burst: immediate return to reset values; wrreq drops asynchronously.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Shared package: state encoding constants (IDLE, SETTLE, WRITE, DONE) and a clog2 helper function. The read controller may later adopt both.
- No sub-module. The settle counter and data/count registers are small enough to stay inline.

Test Plan (bench: DEPTH=8, SETTLE_CYC=4, DATA_W=8; FIFO model with 1-cycle flag lag):
1. Reset, en=1, wrempty=1 held -> first wrreq at cycle 5 after IDLE; 8 accepted writes with wrdata 0..7; wrfull blocks a 9th; burst_done pulses once; wr_cnt=8.
2. Second burst after the model drains -> wrdata continues 8..15; wr_cnt=8 again; no repeated or skipped value.
3. wrempty drops at settle cycle 2 -> return to IDLE, wrreq never asserted, busy high for 3 cycles only.
4. Force wrfull=1 after 3 accepts -> wr_cnt=3; wrdata=3 after the burst; wrreq low the cycle after wrfull is sampled.
5. DATA_INIT=8'hFC, run a burst -> writes FC,FD,FE,FF,00,01,02,03 (wrap-around).
6. Assert rst during WRITE after 2 accepts -> wrreq=0 immediately, wrdata=DATA_INIT, wr_cnt=0, state IDLE; a new burst starts normally.
